mac_op_sequencer: RTL and testbench

- Initiator side of the systolic_array_MAC_if handshake: accepts fp16 operand triples (value, weight, accumulate) on a valid/ready request port and drives one mac_unit through the MAC_shift-then-start startup sequence.
- Waits for the MAC's value_ready, captures out_accumulate and returns it on a valid/ready response port.
- Used for standalone MAC bring-up and as the per-PE operation driver under the systolic array control unit.

---
 rtl/mac_seq_pkg.sv | 23 ++
 rtl/mac_seq_fifo.sv | 59 +++++
 rtl/mac_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_mac_op_sequencer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared types for the MAC operation sequencer.
// Operand word layout, FSM states and default abort limit.
package mac_seq_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        START,
        WAIT,
        RESP
    } mac_seq_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef struct packed {
        fp16_t value;
        fp16_t weight;
        fp16_t accum;
    } mac_operand_t;

endpackage

// File: rtl/mac_seq_fifo.sv
// mac_seq_fifo: synchronous FIFO of operand triples.
// Wrap-bit pointers give full/empty without a separate counter.
module mac_seq_fifo
    import mac_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        nRST,
    input  logic                        push_i,
    input  mac_operand_t                wdata_i,
    input  logic                        pop_i,
    output mac_operand_t                rdata_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    mac_operand_t mem_q [DEPTH];
    ptr_t         wr_ptr_q;
    ptr_t         wr_ptr_d;
    ptr_t         rd_ptr_q;
    ptr_t         rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o  = wr_ptr_q - rd_ptr_q;
    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full_o || do_pop);
    assign rdata_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d = wr_ptr_q + ptr_t'(do_push);
    assign rd_ptr_d = rd_ptr_q + ptr_t'(do_pop);

    // Pointer update; a push into a full FIFO is dropped here
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; entries are only read after being pushed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/mac_op_sequencer.sv
// mac_op_sequencer: buffers operand triples and drives one MAC
// through shift, start, wait-for-result and response handshake.
module mac_op_sequencer
    import mac_seq_pkg::*;
#(
    parameter int unsigned DW         = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_value,
    input  logic [DW-1:0] req_weight,
    input  logic [DW-1:0] req_accum,
    output logic          MAC_shift,
    output logic          start,
    output logic [DW-1:0] in_value,
    output logic [DW-1:0] weight,
    output logic [DW-1:0] in_accumulate,
    input  logic          value_ready,
    input  logic [DW-1:0] out_accumulate,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_timeout,
    output logic          busy
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;

    mac_seq_state_t state_q;
    logic [CW-1:0]  cnt_q;
    logic           mac_shift_q;
    logic           start_q;
    logic           rsp_valid_q;
    logic [DW-1:0]  rsp_data_q;
    logic           rsp_timeout_q;
    logic [DW-1:0]  in_value_q;
    logic [DW-1:0]  weight_q;
    logic [DW-1:0]  in_accum_q;

    mac_operand_t   fifo_wdata;
    mac_operand_t   fifo_head;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FW-1:0]  fifo_count;

    assign fifo_wdata = '{value:  req_value,
                          weight: req_weight,
                          accum:  req_accum};
    assign req_ready  = !fifo_full;
    assign fifo_push  = req_valid && req_ready;
    assign fifo_pop   = !fifo_empty &&
                        ((state_q == IDLE) ||
                         ((state_q == RESP) && rsp_ready));

    mac_seq_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nRST    (nRST),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sequencer FSM: strobes, operands and response all registered
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mac_shift_q   <= 1'b0;
            start_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            in_value_q    <= '0;
            weight_q      <= '0;
            in_accum_q    <= '0;
        end else begin
            mac_shift_q <= 1'b0;
            start_q     <= 1'b0;
            if (fifo_pop) begin
                in_value_q <= fifo_head.value;
                weight_q   <= fifo_head.weight;
                in_accum_q <= fifo_head.accum;
            end
            unique case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        mac_shift_q <= 1'b1;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    start_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= START;
                end
                START: begin
                    cnt_q   <= cnt_q + CW'(1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    // a result landing on the abort cycle still counts
                    if (value_ready) begin
                        rsp_data_q    <= out_accumulate;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_data_q    <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (fifo_pop) begin
                            mac_shift_q <= 1'b1;
                            state_q     <= SHIFT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MAC_shift     = mac_shift_q;
    assign start         = start_q;
    assign in_value      = in_value_q;
    assign weight        = weight_q;
    assign in_accumulate = in_accum_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign busy          = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_mac_op_sequencer.sv
// tb_mac_op_sequencer: directed and random checks of the sequencer
// against a stand-in MAC and a queue-based response model.
module tb_mac_op_sequencer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int TO    = 15;

    logic          clk = 1'b0;
    logic          nRST = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_value = '0;
    logic [DW-1:0] req_weight = '0;
    logic [DW-1:0] req_accum = '0;
    logic          MAC_shift;
    logic          start;
    logic [DW-1:0] in_value;
    logic [DW-1:0] weight;
    logic [DW-1:0] in_accumulate;
    logic          value_ready;
    logic [DW-1:0] out_accumulate = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_timeout;
    logic          busy;

    always #5 clk = ~clk;

    mac_op_sequencer #(
        .DW             (DW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT        (TO)
    ) dut (
        .clk            (clk),
        .nRST           (nRST),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_value      (req_value),
        .req_weight     (req_weight),
        .req_accum      (req_accum),
        .MAC_shift      (MAC_shift),
        .start          (start),
        .in_value       (in_value),
        .weight         (weight),
        .in_accumulate  (in_accumulate),
        .value_ready    (value_ready),
        .out_accumulate (out_accumulate),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_shift = 0;
    int n_rsp = 0;
    int cyc = 0;
    logic rnd_en = 1'b0;
    logic stub_vr = 1'b0;
    logic spur_vr = 1'b0;
    int rem = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          to;
    } exp_t;
    exp_t expq[$];
    int   start_cyc[$];

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_to = 1'b0;

    assign value_ready = stub_vr | spur_vr;

    // Stand-in MAC: fp16 35.0 for the bring-up triple, a mixing
    // function otherwise, so wrong operands show up in the result
    function automatic logic [DW-1:0] mac_fn(
        input logic [DW-1:0] v,
        input logic [DW-1:0] w,
        input logic [DW-1:0] a
    );
        if (v == 16'h4B80 && w == 16'h4000 && a == 16'h4500)
            return 16'h5060;
        return (v + w) ^ a;
    endfunction

    // Result latency after start is carried in accum[11:8]; 0 = never
    function automatic int lat_of(input logic [DW-1:0] a);
        return int'(a[11:8]);
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // MAC stand-in: one value_ready pulse lat cycles after start
    always @(negedge clk) begin
        stub_vr = 1'b0;
        if (!nRST) begin
            rem = 0;
        end else if (start) begin
            rem = lat_of(in_accumulate);
        end else if (rem != 0) begin
            rem--;
            if (rem == 0) begin
                stub_vr = 1'b1;
                out_accumulate = mac_fn(in_value, weight, in_accumulate);
            end
        end
    end

    // Model and scoreboard: a result is valid only if it arrives
    // before TIMEOUT cycles have elapsed since start, else abort
    always @(negedge clk) begin
        if (nRST) begin
            if (req_valid && req_ready) begin
                exp_t e;
                int   l;
                l = lat_of(req_accum);
                e.to = (l == 0) || (l >= TO);
                e.data = e.to ? '0 : mac_fn(req_value, req_weight, req_accum);
                expq.push_back(e);
            end
            if (MAC_shift || start)
                check("strobe_overlap", {31'd0, MAC_shift & start}, 0);
            if (MAC_shift) n_shift++;
            if (start) start_cyc.push_back(cyc);
            if (prev_stall) begin
                check("hold_valid", {31'd0, rsp_valid}, 1);
                check("hold_data", {16'd0, rsp_data}, {16'd0, prev_data});
                check("hold_to", {31'd0, rsp_timeout}, {31'd0, prev_to});
            end
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    check("rsp_unexpected", {31'd0, rsp_valid}, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                    check("rsp_to", {31'd0, rsp_timeout}, {31'd0, e.to});
                    n_rsp++;
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            prev_to    = rsp_timeout;
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic push(input logic [DW-1:0] v,
                        input logic [DW-1:0] w,
                        input logic [DW-1:0] a,
                        output int n);
        logic ok;
        req_valid  = 1'b1;
        req_value  = v;
        req_weight = w;
        req_accum  = a;
        n = 0;
        do begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        req_valid = 1'b0;
        if (!ok) check("push_stuck", {31'd0, ok}, 1);
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return MAC_shift;
            1:       return start;
            default: return rsp_valid;
        endcase
    endfunction

    // Wait (bounded) for an output to go high, sampled at negedge
    task automatic wait_out(input int sel, input string tag,
                            input int lim, output int k);
        logic s;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            s = sig_of(sel);
        end while (!s && k < lim);
        if (!s) check(tag, {31'd0, s}, 1);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((expq.size() != 0 || busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_left"}, expq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int k;
        int s0;
        int r0;
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int s0;
        int r0;

        // reset values
        #12;
        check("rst_req_ready", {31'd0, req_ready}, 1);
        check("rst_shift", {31'd0, MAC_shift}, 0);
        check("rst_start", {31'd0, start}, 0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_in_value", {16'd0, in_value}, 0);
        @(negedge clk);
        nRST = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;

        // bring-up triple: issue latency, strobe order, result
        push(16'h4B80, 16'h4000, 16'h4500, n);
        check("t1_accept", n, 1);
        @(negedge clk);
        check("t1_shift_early", {31'd0, MAC_shift}, 0);
        @(negedge clk);
        check("t1_shift", {31'd0, MAC_shift}, 1);
        check("t1_start_low", {31'd0, start}, 0);
        check("t1_operand", {16'd0, in_value}, 32'h4B80);
        @(negedge clk);
        check("t1_shift_drop", {31'd0, MAC_shift}, 0);
        check("t1_start", {31'd0, start}, 1);
        @(negedge clk);
        check("t1_start_drop", {31'd0, start}, 0);
        wait_out(2, "t1_rsp_wait", 40, k);
        check("t1_data", {16'd0, rsp_data}, 32'h5060);
        check("t1_to", {31'd0, rsp_timeout}, 0);
        drain("t1");

        // back-to-back issue, 4-cycle MAC: period is latency + 3
        start_cyc.delete();
        r0 = n_rsp;
        for (int i = 0; i < 4; i++) begin
            push(16'h3C00 + 16'(i), 16'h4000 + 16'(i * 16),
                 16'h0400 | 16'(i), n);
            check("t2_accept", n, 1);
        end
        drain("t2");
        check("t2_rsp_count", n_rsp - r0, 4);
        check("t2_starts", start_cyc.size(), 4);
        for (int i = 1; i < 4 && i < start_cyc.size(); i++)
            check("t2_period", start_cyc[i] - start_cyc[i-1], 7);

        // abort after TIMEOUT cycles, then a normal op
        push(16'h1111, 16'h2222, 16'h0000, n);
        push(16'h3333, 16'h4444, 16'h0203, n);
        wait_out(1, "t3_start_wait", 20, k);
        wait_out(2, "t3_rsp_wait", 40, k);
        check("t3_to_latency", k, TO);
        check("t3_to_flag", {31'd0, rsp_timeout}, 1);
        check("t3_to_data", {16'd0, rsp_data}, 0);
        @(negedge clk);
        wait_out(2, "t3_rsp2_wait", 40, k);
        check("t3_next_to", {31'd0, rsp_timeout}, 0);
        check("t3_next_data", {16'd0, rsp_data},
              {16'd0, mac_fn(16'h3333, 16'h4444, 16'h0203)});
        drain("t3");

        // result on the last WAIT cycle wins; one later aborts
        push(16'h0102, 16'h0304, 16'h0E55, n);
        wait_out(2, "t4_rsp_wait", 40, k);
        check("t4_edge_to", {31'd0, rsp_timeout}, 0);
        check("t4_edge_data", {16'd0, rsp_data},
              {16'd0, mac_fn(16'h0102, 16'h0304, 16'h0E55)});
        drain("t4a");
        push(16'h0506, 16'h0708, 16'h0F66, n);
        wait_out(2, "t4_rsp2_wait", 40, k);
        check("t4_late_to", {31'd0, rsp_timeout}, 1);
        drain("t4b");

        // back-pressure: response held, FIFO fills, 5th refused
        rsp_ready = 1'b0;
        push(16'hA000, 16'hB000, 16'h0211, n);
        wait_out(2, "t5_rsp_wait", 40, k);
        @(posedge clk);
        #1;
        s0 = n_shift;
        for (int i = 0; i < 4; i++) begin
            push(16'hA100 + 16'(i), 16'hB100, 16'h0320 + 16'(i), n);
            check("t5_accept", n, 1);
        end
        req_valid  = 1'b1;
        req_value  = 16'hA200;
        req_weight = 16'hB200;
        req_accum  = 16'h0130;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_full", {31'd0, req_ready}, 0);
        end
        check("t5_no_shift", n_shift - s0, 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t5_resp_hs", {31'd0, MAC_shift}, 0);
        @(negedge clk);
        check("t5_resume", {31'd0, MAC_shift}, 1);
        check("t5_room", {31'd0, req_ready}, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain("t5");

        // spurious value_ready in IDLE and SHIFT is ignored
        spur_vr = 1'b1;
        @(posedge clk);
        #1;
        spur_vr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_idle_rsp", {31'd0, rsp_valid}, 0);
            check("t6_idle_busy", {31'd0, busy}, 0);
        end
        @(posedge clk);
        #1;
        push(16'h1234, 16'h5678, 16'h0077, n);
        wait_out(0, "t6_shift_wait", 20, k);
        spur_vr = 1'b1;
        @(negedge clk);
        spur_vr = 1'b0;
        check("t6_start", {31'd0, start}, 1);
        check("t6_shift_rsp", {31'd0, rsp_valid}, 0);
        wait_out(2, "t6_rsp_wait", 40, k);
        check("t6_to", {31'd0, rsp_timeout}, 1);
        drain("t6");

        // reset in WAIT with two ops queued
        push(16'h0A0A, 16'h0B0B, 16'h0001, n);
        push(16'h0C0C, 16'h0D0D, 16'h0002, n);
        push(16'h0E0E, 16'h0F0F, 16'h0003, n);
        wait_out(1, "t7_start_wait", 20, k);
        repeat (3) @(negedge clk);
        #2;
        nRST = 1'b0;
        #1;
        check("t7_shift", {31'd0, MAC_shift}, 0);
        check("t7_start", {31'd0, start}, 0);
        check("t7_rsp_valid", {31'd0, rsp_valid}, 0);
        check("t7_req_ready", {31'd0, req_ready}, 1);
        check("t7_busy", {31'd0, busy}, 0);
        check("t7_operand", {16'd0, in_accumulate}, 0);
        expq.delete();
        @(posedge clk);
        #2;
        nRST = 1'b1;
        s0 = n_shift;
        repeat (30) @(negedge clk);
        check("t7_no_stale", n_shift - s0, 0);
        check("t7_idle", {31'd0, busy}, 0);
        @(posedge clk);
        #1;

        // random operands, latencies and consumer stalls
        r0 = n_rsp;
        rnd_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [DW-1:0] a;
            a = 16'($urandom);
            a[11:8] = 4'($urandom_range(0, 15));
            push(16'($urandom), 16'($urandom), a, n);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_en = 1'b0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        drain("t8");
        check("t8_rsp_count", n_rsp - r0, 24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
